// File: rtl/sap1_datapath.sv
// SAP-1 datapath: shared bus, PC, MAR, 16x8 RAM, IR, A, B, adder/subtractor and OUT,
// driven by the sequencing controller's strobes, plus a host RAM programming port.
module sap1_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pc_en_i,
  input  logic              pc_inc_i,
  input  logic              mem_load_i,
  input  logic              mem_en_i,
  input  logic              ins_load_i,
  input  logic              ins_en_i,
  input  logic              a_load_i,
  input  logic              a_en_i,
  input  logic              adder_sub_i,
  input  logic              adder_en_i,
  input  logic              b_load_i,
  input  logic              output_load_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic [3:0]        opcode_o,
  output logic [DATA_W-1:0] out_o,
  output logic [DATA_W-1:0] bus_o,
  output logic              carry_o,
  output logic              bus_conflict_o
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned OPND_W = DATA_W - OPC_W;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] ram [DEPTH];

  logic [DATA_W-1:0] b_operand;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] bus;
  logic [4:0]        en_vec;
  logic              multi_en;

  // Subtract is A + ~B + 1, so the ninth bit reads as "no borrow".
  always_comb begin
    b_operand = adder_sub_i ? ~b_reg : b_reg;
    sum       = {1'b0, a_reg} + {1'b0, b_operand} + (DATA_W+1)'(adder_sub_i);
  end

  // Fixed-priority bus mux; an idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (pc_en_i)         bus = DATA_W'(pc);
    else if (mem_en_i)   bus = ram[mar];
    else if (ins_en_i)   bus = DATA_W'(ir[OPND_W-1:0]);
    else if (a_en_i)     bus = a_reg;
    else if (adder_en_i) bus = sum[DATA_W-1:0];
  end

  always_comb begin
    en_vec   = {pc_en_i, mem_en_i, ins_en_i, a_en_i, adder_en_i};
    multi_en = ($countones(en_vec) > 1);
  end

  // Architectural registers; every load samples the pre-edge bus.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pc             <= '0;
      mar            <= '0;
      ir             <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      out_o          <= '0;
      bus_conflict_o <= 1'b0;
    end else begin
      if (pc_inc_i)      pc    <= pc + ADDR_W'(1);
      if (mem_load_i)    mar   <= bus[ADDR_W-1:0];
      if (ins_load_i)    ir    <= bus;
      if (a_load_i)      a_reg <= bus;
      if (b_load_i)      b_reg <= bus;
      if (output_load_i) out_o <= bus;
      if (multi_en)      bus_conflict_o <= 1'b1;
    end
  end

  // Host write port is independent of reset; reads see old data on a same-edge write.
  always_ff @(posedge clk_i) begin
    if (prog_we_i) ram[prog_addr_i] <= prog_data_i;
  end

  assign opcode_o = ir[DATA_W-1 -: OPC_W];
  assign bus_o    = bus;
  assign carry_o  = sum[DATA_W];

endmodule
